gate_controller: RTL and testbench
==================================

GATE_CONTROLLER -- requirements
Module: GATE_CONTROLLER

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4: consecutive stable synchronized samples required to accept a sensor level change, legal range 1-15.
REQ-002 Parameter HOLD_CYC, default 8: cycles a barrier stays open after the car has cleared its sensor, legal range 1-255.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port entry_sensor, input, 1: raw entry loop detector, asynchronous to clk, 1 = car present.
REQ-006 Port exit_sensor, input, 1: raw exit loop detector, asynchronous to clk, 1 = car present.
REQ-007 Port parking_full, input, 1: garage-full flag from the parking counter, synchronous to clk.
REQ-008 Port car_in, output, 1: single-cycle pulse meaning one car has entered.
REQ-009 Port car_out, output, 1: single-cycle pulse meaning one car has left.
REQ-010 Port entry_barrier, output, 1: 1 = entry barrier open.
REQ-011 Port exit_barrier, output, 1: 1 = exit barrier open.
REQ-012 Port entry_denied, output, 1: 1 = a car is waiting at a full garage.

Function
REQ-013 Each sensor SHALL pass through a 2-flop synchronizer, then a debounce counter that updates the filtered level only after DEBOUNCE_CYC consecutive synchronized samples differ from the current filtered level.
REQ-014 A differing sample run shorter than DEBOUNCE_CYC SHALL clear the debounce counter and leave the filtered level unchanged.
REQ-015 A clean raw change SHALL appear on the filtered level exactly DEBOUNCE_CYC+2 rising edges later.
REQ-016 Entry FSM states SHALL be IDLE, DENY, OPEN and HOLD, and all FSM outputs SHALL be registered.
REQ-017 IDLE SHALL go to OPEN on a filtered-entry rising edge when parking_full=0, and to DENY when parking_full=1.
REQ-018 parking_full SHALL be sampled only in that IDLE decision cycle, so a change of parking_full while in OPEN or HOLD has no effect.
REQ-019 In DENY, entry_denied SHALL be 1, and the FSM SHALL return to IDLE when filtered entry falls.
REQ-020 A later rising edge after leaving DENY SHALL be re-evaluated against parking_full.
REQ-021 In OPEN, entry_barrier SHALL be 1, and a filtered-entry falling edge SHALL move the FSM to HOLD and raise a car_in request.
REQ-022 In HOLD, entry_barrier SHALL remain 1 for HOLD_CYC cycles and then the FSM SHALL return to IDLE with the barrier at 0.
REQ-023 A new filtered-entry rising edge during HOLD SHALL go directly to OPEN with no new full check and with the barrier kept at 1.
REQ-024 The exit FSM SHALL have states IDLE, OPEN and HOLD, behave like the entry FSM without a full check or DENY state, drive exit_barrier and raise a car_out request.
REQ-025 Each request SHALL produce exactly one 1-cycle pulse, registered on the edge after the falling-edge detection.
REQ-026 car_in and car_out SHALL never be 1 in the same cycle.
REQ-027 On a same-cycle collision, car_in SHALL be issued first and car_out SHALL be held in a 1-deep pending flag and issued the next cycle.
REQ-028 A new car_out request arriving while the pending flag is set is impossible, because HOLD_CYC is at least 1 and DEBOUNCE_CYC is at least 1, so no extra queueing is required.
REQ-029 Latency from a raw sensor rise to barrier=1 SHALL be DEBOUNCE_CYC+3 edges.

Reset
REQ-030 While rst=1, all outputs SHALL be 0, both FSMs SHALL be in IDLE, and all debounce counters, filtered levels, synchronizers and the pending flag SHALL be 0.
REQ-031 rst SHALL take effect immediately without a clock edge.
REQ-032 Reset asserted mid-operation SHALL close a barrier at once and discard any pending pulse.
REQ-033 After rst is released, a sensor already high SHALL be treated as a new rising edge once debounced.

Verification (DEBOUNCE_CYC=4, HOLD_CYC=8)
REQ-034 Entry, garage not full: entry_sensor high 20 cycles then low -> entry_barrier=1 at edge 7, car_in single pulse at edge 7 after the fall, barrier=0 exactly 8 cycles later.
REQ-035 Glitch rejection: entry_sensor high for 3 cycles -> no barrier, no car_in, filtered level unchanged.
REQ-036 Full garage: parking_full=1 and entry_sensor high 10 cycles -> entry_denied=1, entry_barrier=0, no car_in; entry_denied returns to 0 after the debounced fall.
REQ-037 Collision: entry and exit sensors fall on the same cycle -> car_in pulse at cycle N, car_out pulse at cycle N+1, never both high together.
REQ-038 Mid-operation reset: rst pulsed while exit FSM is in HOLD -> exit_barrier=0 immediately, no car_out, FSM restarts from IDLE.
REQ-039 Re-entry during HOLD: second car arrives during HOLD -> entry_barrier stays 1 continuously, two separate car_in pulses are issued.

Source files
------------

// File: rtl/gate_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gate_controller                                              |
// | Description : Parking-garage gate controller. Synchronises and debounces   |
// |               the entry/exit loop detectors, runs an entry FSM (with       |
// |               garage-full denial) and an exit FSM, drives the barriers and |
// |               issues single-cycle car_in / car_out pulses that never       |
// |               overlap.                                                     |
// | Ports       : clk, rst (async, active-high)                                |
// |               entry_sensor, exit_sensor : raw detectors, async to clk      |
// |               parking_full              : garage full, sync to clk         |
// |               car_in, car_out           : 1-cycle event pulses             |
// |               entry_barrier, exit_barrier : 1 = barrier open               |
// |               entry_denied              : 1 = car waiting at full garage   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gate_controller #(
  parameter int DEBOUNCE_CYC = 4,   // 1..15
  parameter int HOLD_CYC     = 8    // 1..255
) (
  input  logic clk,
  input  logic rst,
  input  logic entry_sensor,
  input  logic exit_sensor,
  input  logic parking_full,
  output logic car_in,
  output logic car_out,
  output logic entry_barrier,
  output logic exit_barrier,
  output logic entry_denied
);

  localparam logic [3:0] c_DB_LAST   = 4'(DEBOUNCE_CYC - 1);
  localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_CYC - 1);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_DENY = 2'd1;
  localparam logic [1:0] c_ST_OPEN = 2'd2;
  localparam logic [1:0] c_ST_HOLD = 2'd3;

  // Bit 0 = entry channel, bit 1 = exit channel.
  logic [1:0] w_raw;
  logic [1:0] w_filt;
  logic [1:0] r_filt_d;

  assign w_raw = {exit_sensor, entry_sensor};

  // --------------------------------------------------------------------------
  // Per-sensor 2-flop synchroniser followed by a debounce filter. The filtered
  // level only flips after DEBOUNCE_CYC consecutive synchronised samples that
  // disagree with it; any agreeing sample restarts the count.
  // --------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
      logic       r_sync1;
      logic       r_sync2;
      logic       r_level;
      logic [3:0] r_cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_level <= 1'b0;
          r_cnt   <= 4'd0;
        end else begin
          r_sync1 <= w_raw[gi];
          r_sync2 <= r_sync1;
          if (r_sync2 == r_level) begin
            r_cnt <= 4'd0;
          end else if (r_cnt == c_DB_LAST) begin
            r_level <= r_sync2;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
      end

      assign w_filt[gi] = r_level;
    end
  endgenerate

  // Edge detection on the filtered levels.
  logic w_ent_rise, w_ent_fall, w_ext_rise, w_ext_fall;
  assign w_ent_rise = w_filt[0] & ~r_filt_d[0];
  assign w_ent_fall = ~w_filt[0] & r_filt_d[0];
  assign w_ext_rise = w_filt[1] & ~r_filt_d[1];
  assign w_ext_fall = ~w_filt[1] & r_filt_d[1];

  // --------------------------------------------------------------------------
  // FSM state and hold counters
  // --------------------------------------------------------------------------
  logic [1:0] r_ent_state, w_ent_next;
  logic [1:0] r_ext_state, w_ext_next;
  logic [7:0] r_ent_hold, r_ext_hold;
  logic       w_in_req, w_out_req;
  logic       r_pend;

  // Entry FSM. parking_full is only looked at when leaving IDLE; a rising edge
  // during HOLD reopens without a new full check (that car was already
  // admitted behind the previous one while the barrier was still up).
  always_comb begin
    w_ent_next = r_ent_state;
    w_in_req   = 1'b0;
    case (r_ent_state)
      c_ST_IDLE: begin
        if (w_ent_rise) w_ent_next = parking_full ? c_ST_DENY : c_ST_OPEN;
      end
      c_ST_DENY: begin
        if (w_ent_fall) w_ent_next = c_ST_IDLE;
      end
      c_ST_OPEN: begin
        if (w_ent_fall) begin
          w_ent_next = c_ST_HOLD;
          w_in_req   = 1'b1;
        end
      end
      c_ST_HOLD: begin
        if (w_ent_rise)                      w_ent_next = c_ST_OPEN;
        else if (r_ent_hold == c_HOLD_LAST)  w_ent_next = c_ST_IDLE;
      end
      default: w_ent_next = c_ST_IDLE;
    endcase
  end

  // Exit FSM: same shape, no full check, DENY never entered.
  always_comb begin
    w_ext_next = r_ext_state;
    w_out_req  = 1'b0;
    case (r_ext_state)
      c_ST_IDLE: begin
        if (w_ext_rise) w_ext_next = c_ST_OPEN;
      end
      c_ST_OPEN: begin
        if (w_ext_fall) begin
          w_ext_next = c_ST_HOLD;
          w_out_req  = 1'b1;
        end
      end
      c_ST_HOLD: begin
        if (w_ext_rise)                      w_ext_next = c_ST_OPEN;
        else if (r_ext_hold == c_HOLD_LAST)  w_ext_next = c_ST_IDLE;
      end
      default: w_ext_next = c_ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt_d      <= 2'b00;
      r_ent_state   <= c_ST_IDLE;
      r_ext_state   <= c_ST_IDLE;
      r_ent_hold    <= 8'd0;
      r_ext_hold    <= 8'd0;
      entry_barrier <= 1'b0;
      exit_barrier  <= 1'b0;
      entry_denied  <= 1'b0;
      car_in        <= 1'b0;
      car_out       <= 1'b0;
      r_pend        <= 1'b0;
    end else begin
      r_filt_d    <= w_filt;
      r_ent_state <= w_ent_next;
      r_ext_state <= w_ext_next;

      // Counters run only while in HOLD; they are zero on every HOLD entry.
      r_ent_hold <= (r_ent_state == c_ST_HOLD) ? r_ent_hold + 8'd1 : 8'd0;
      r_ext_hold <= (r_ext_state == c_ST_HOLD) ? r_ext_hold + 8'd1 : 8'd0;

      entry_barrier <= (w_ent_next == c_ST_OPEN) || (w_ent_next == c_ST_HOLD);
      exit_barrier  <= (w_ext_next == c_ST_OPEN) || (w_ext_next == c_ST_HOLD);
      entry_denied  <= (w_ent_next == c_ST_DENY);

      // car_in wins a collision; car_out is parked in r_pend for one cycle.
      car_in <= w_in_req;
      if (w_in_req) begin
        car_out <= 1'b0;
        r_pend  <= r_pend | w_out_req;
      end else begin
        car_out <= r_pend | w_out_req;
        r_pend  <= r_pend & w_out_req;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_gate_controller                                           |
// | Description : Self-checking bench for gate_controller (DEBOUNCE_CYC=4,     |
// |               HOLD_CYC=8). Table rows hold inputs for N cycles and check   |
// |               the expected output word every cycle; reset corner cases are |
// |               hand-written sequences.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_gate_controller;

  logic clk = 1'b0;
  logic rst;
  logic entry_sensor, exit_sensor, parking_full;
  logic car_in, car_out, entry_barrier, exit_barrier, entry_denied;

  int total = 0;
  int bad   = 0;

  // Expected output word: {car_in, car_out, entry_barrier, exit_barrier, entry_denied}
  localparam logic [4:0] CIN  = 5'b10000;
  localparam logic [4:0] COUT = 5'b01000;
  localparam logic [4:0] EB   = 5'b00100;
  localparam logic [4:0] XB   = 5'b00010;
  localparam logic [4:0] DEN  = 5'b00001;
  localparam logic [4:0] NONE = 5'b00000;

  typedef struct {
    logic       ent;
    logic       ext;
    logic       full;
    int         cyc;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  gate_controller #(.DEBOUNCE_CYC(4), .HOLD_CYC(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .entry_sensor  (entry_sensor),
    .exit_sensor   (exit_sensor),
    .parking_full  (parking_full),
    .car_in        (car_in),
    .car_out       (car_out),
    .entry_barrier (entry_barrier),
    .exit_barrier  (exit_barrier),
    .entry_denied  (entry_denied)
  );

  always #5 clk = ~clk;

  function automatic void add(logic e, logic x, logic f, int n, logic [4:0] ex);
    vec_t v;
    v.ent  = e;
    v.ext  = x;
    v.full = f;
    v.cyc  = n;
    v.exp  = ex;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, logic [4:0] ex);
    logic [4:0] got;
    got = {car_in, car_out, entry_barrier, exit_barrier, entry_denied};
    total++;
    if (got !== ex) begin
      bad++;
      $display("FAIL %s t=%0t got={in,out,eb,xb,den}=%b exp=%b", name, $time, got, ex);
    end
  endtask

  // Drive inputs, then check outputs 1 time unit after each of the next n edges.
  task automatic run(string name, logic e, logic x, logic f, int n, logic [4:0] ex);
    entry_sensor = e;
    exit_sensor  = x;
    parking_full = f;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check(name, ex);
    end
  endtask

  initial begin
    // Normal entry; parking_full toggled while OPEN/HOLD must be ignored.
    add(1,0,0, 6,NONE); add(1,0,0, 1,EB);     add(1,0,1,13,EB);
    add(0,0,1, 6,EB);   add(0,0,1, 1,CIN|EB); add(0,0,1, 7,EB);
    add(0,0,1, 1,NONE); add(0,0,0, 2,NONE);
    // Glitches of 3 cycles on both sensors are rejected.
    add(1,0,0, 3,NONE); add(0,0,0,12,NONE);
    add(0,1,0, 3,NONE); add(0,0,0,12,NONE);
    // Full garage: denied, cleared on debounced fall.
    add(1,0,1, 6,NONE); add(1,0,1, 1,DEN);    add(1,0,1, 3,DEN);
    add(0,0,1, 6,DEN);  add(0,0,1, 1,NONE);   add(0,0,1, 2,NONE);
    // Next arrival re-evaluated against a now-clear garage.
    add(1,0,0, 6,NONE); add(1,0,0, 1,EB);     add(1,0,0, 3,EB);
    add(0,0,0, 6,EB);   add(0,0,0, 1,CIN|EB); add(0,0,0, 7,EB);
    add(0,0,0, 1,NONE); add(0,0,0, 2,NONE);
    // Collision: car_in at N, car_out at N+1.
    add(1,1,0, 6,NONE);  add(1,1,0, 1,EB|XB);      add(1,1,0, 3,EB|XB);
    add(0,0,0, 6,EB|XB); add(0,0,0, 1,CIN|EB|XB);  add(0,0,0, 1,COUT|EB|XB);
    add(0,0,0, 6,EB|XB); add(0,0,0, 1,NONE);       add(0,0,0, 2,NONE);
    // Single exit.
    add(0,1,0, 6,NONE); add(0,1,0, 1,XB);      add(0,1,0, 2,XB);
    add(0,0,0, 6,XB);   add(0,0,0, 1,COUT|XB); add(0,0,0, 7,XB);
    add(0,0,0, 1,NONE); add(0,0,0, 2,NONE);
    // Re-entry during HOLD: barrier stays up, two car_in pulses.
    add(1,0,0, 6,NONE); add(1,0,0, 1,EB);     add(1,0,0, 3,EB);
    add(0,0,0, 6,EB);   add(0,0,0, 1,CIN|EB); add(1,0,0,10,EB);
    add(0,0,0, 6,EB);   add(0,0,0, 1,CIN|EB); add(0,0,0, 7,EB);
    add(0,0,0, 1,NONE); add(0,0,0, 2,NONE);

    // Reset state, including with sensors active during reset.
    rst = 1'b1; entry_sensor = 1'b0; exit_sensor = 1'b0; parking_full = 1'b0;
    #2;
    check("reset_async", NONE);
    run("reset_hold", 1, 1, 1, 8, NONE);
    run("reset_quiet", 0, 0, 0, 3, NONE);
    rst = 1'b0;

    for (int k = 0; k < tbl.size(); k++)
      run($sformatf("vec%0d", k), tbl[k].ent, tbl[k].ext, tbl[k].full, tbl[k].cyc, tbl[k].exp);

    // Reset while the exit FSM is in HOLD: barrier drops without a clock edge.
    run("xr_rise", 0,1,0, 6,NONE); run("xr_open", 0,1,0, 4,XB);
    run("xr_fall", 0,0,0, 6,XB);   run("xr_cout", 0,0,0, 1,COUT|XB);
    run("xr_hold", 0,0,0, 2,XB);
    #3 rst = 1'b1;
    #1 check("xr_rst_async", NONE);
    @(posedge clk); #1;
    check("xr_rst_edge", NONE);
    rst = 1'b0;
    run("xr_after", 0,0,0,15,NONE);
    run("xr_re_rise", 0,1,0, 6,NONE); run("xr_re_open", 0,1,0, 1,XB);
    run("xr_re_fall", 0,0,0, 6,XB);   run("xr_re_cout", 0,0,0, 1,COUT|XB);
    run("xr_re_hold", 0,0,0, 7,XB);   run("xr_re_shut", 0,0,0, 1,NONE);

    // Reset right after a collision discards the pending car_out.
    run("pd_rise", 1,1,0, 6,NONE);  run("pd_open", 1,1,0, 3,EB|XB);
    run("pd_fall", 0,0,0, 6,EB|XB); run("pd_cin", 0,0,0, 1,CIN|EB|XB);
    #3 rst = 1'b1;
    #1 check("pd_rst_async", NONE);
    @(posedge clk); #1;
    check("pd_no_cout", NONE);
    rst = 1'b0;
    run("pd_after", 0,0,0,15,NONE);

    // Sensor already high when reset releases counts as a new arrival.
    entry_sensor = 1'b1;
    rst = 1'b1;
    #1 check("hr_rst", NONE);
    run("hr_in_rst", 1,0,0, 3,NONE);
    rst = 1'b0;
    run("hr_deb",  1,0,0, 6,NONE); run("hr_open", 1,0,0, 1,EB);
    run("hr_fall", 0,0,0, 6,EB);   run("hr_cin",  0,0,0, 1,CIN|EB);
    run("hr_hold", 0,0,0, 7,EB);   run("hr_shut", 0,0,0, 1,NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
